// File: rtl/sram_pkg.sv
// Shared types for the SRAM request controller: controller state encoding.
package sram_pkg;
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/sram_rd_port.sv
// One read port of the controller: single-entry response stage with a hold
// register and same-cycle write forwarding for a read that collides with a write.
module sram_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  logic                  accept;
  logic                  fresh;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [DATA_WIDTH-1:0] live_data;

  // Handshake: a request is taken when req_valid && req_ready; a response is
  // consumed when rsp_valid && rsp_ready. The stage frees up in the cycle it drains.
  assign req_ready = run && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign sram_addr = req_addr;

  // In the response cycle the SRAM output is live; afterwards only hold_data is trusted.
  assign live_data = fwd_hit ? fwd_data : sram_rdata;
  assign rsp_data  = !rst_n ? '0 : (fresh ? live_data : hold_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      fresh     <= 1'b0;
      fwd_hit   <= 1'b0;
      fwd_data  <= '0;
      hold_data <= '0;
    end else begin
      if (accept) begin
        rsp_valid <= 1'b1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      fresh   <= accept;
      fwd_hit <= accept && wr_en && (wr_addr == req_addr);
      if (accept) begin
        fwd_data <= wr_data;
      end
      if (fresh) begin
        hold_data <= live_data;
      end
    end
  end
endmodule

// File: rtl/sram_req_ctrl.sv
// Front end for a 2R1W SRAM: clears every word after reset, then serves one
// write port and two independent read ports with one-cycle read latency.
module sram_req_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wreq_valid_i,
  output logic                  wreq_ready_o,
  input  logic [ADDR_WIDTH-1:0] wreq_addr_i,
  input  logic [DATA_WIDTH-1:0] wreq_data_i,
  input  logic                  rreq_a_valid_i,
  output logic                  rreq_a_ready_o,
  input  logic [ADDR_WIDTH-1:0] rreq_a_addr_i,
  output logic                  rrsp_a_valid_o,
  input  logic                  rrsp_a_ready_i,
  output logic [DATA_WIDTH-1:0] rrsp_a_data_o,
  input  logic                  rreq_b_valid_i,
  output logic                  rreq_b_ready_o,
  input  logic [ADDR_WIDTH-1:0] rreq_b_addr_i,
  output logic                  rrsp_b_valid_o,
  input  logic                  rrsp_b_ready_i,
  output logic [DATA_WIDTH-1:0] rrsp_b_data_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_waddr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_ra_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_ra_i,
  output logic [ADDR_WIDTH-1:0] sram_addr_rb_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_rb_i,
  output logic                  init_done_o,
  output state_e                dbg_state_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_e                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  run;
  logic                  wr_fire;

  assign run          = rst_ni && (state == RUN);
  assign wreq_ready_o = run;
  assign wr_fire      = wreq_valid_i && wreq_ready_o;
  assign dbg_state_o  = state;

  always_comb begin
    sram_we_o    = 1'b0;
    sram_waddr_o = wreq_addr_i;
    sram_wdata_o = wreq_data_i;
    if (rst_ni && (state == INIT)) begin
      sram_we_o    = 1'b1;
      sram_waddr_o = clr_cnt;
      sram_wdata_o = '0;
    end else if (wr_fire) begin
      sram_we_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= INIT;
      clr_cnt     <= '0;
      init_done_o <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state       <= RUN;
            init_done_o <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
      endcase
    end
  end

  sram_rd_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_a (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .run        (run),
    .req_valid  (rreq_a_valid_i),
    .req_addr   (rreq_a_addr_i),
    .req_ready  (rreq_a_ready_o),
    .rsp_valid  (rrsp_a_valid_o),
    .rsp_ready  (rrsp_a_ready_i),
    .rsp_data   (rrsp_a_data_o),
    .sram_addr  (sram_addr_ra_o),
    .sram_rdata (sram_rdata_ra_i),
    .wr_en      (wr_fire),
    .wr_addr    (wreq_addr_i),
    .wr_data    (wreq_data_i)
  );

  sram_rd_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_b (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .run        (run),
    .req_valid  (rreq_b_valid_i),
    .req_addr   (rreq_b_addr_i),
    .req_ready  (rreq_b_ready_o),
    .rsp_valid  (rrsp_b_valid_o),
    .rsp_ready  (rrsp_b_ready_i),
    .rsp_data   (rrsp_b_data_o),
    .sram_addr  (sram_addr_rb_o),
    .sram_rdata (sram_rdata_rb_i),
    .wr_en      (wr_fire),
    .wr_addr    (wreq_addr_i),
    .wr_data    (wreq_data_i)
  );
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: behavioural 2R1W SRAM, directed stimulus, and a
// response scoreboard per read port.
module tb_sram_req_ctrl;
  import sram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          wreq_valid_i, wreq_ready_o;
  logic [AW-1:0] wreq_addr_i;
  logic [DW-1:0] wreq_data_i;
  logic          rreq_a_valid_i, rreq_a_ready_o, rrsp_a_valid_o, rrsp_a_ready_i;
  logic [AW-1:0] rreq_a_addr_i;
  logic [DW-1:0] rrsp_a_data_o;
  logic          rreq_b_valid_i, rreq_b_ready_o, rrsp_b_valid_o, rrsp_b_ready_i;
  logic [AW-1:0] rreq_b_addr_i;
  logic [DW-1:0] rrsp_b_data_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_waddr_o, sram_addr_ra_o, sram_addr_rb_o;
  logic [DW-1:0] sram_wdata_o, sram_rdata_ra_i, sram_rdata_rb_i;
  logic          init_done_o;
  state_e        dbg_state_o;

  int total = 0;
  int bad = 0;
  int init_wr_cnt = 0;
  logic [DW-1:0] exp_a_q[$];
  logic [DW-1:0] exp_b_q[$];

  // clock / reset
  always #5 clk = ~clk;

  sram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .wreq_valid_i(wreq_valid_i), .wreq_ready_o(wreq_ready_o),
    .wreq_addr_i(wreq_addr_i), .wreq_data_i(wreq_data_i),
    .rreq_a_valid_i(rreq_a_valid_i), .rreq_a_ready_o(rreq_a_ready_o), .rreq_a_addr_i(rreq_a_addr_i),
    .rrsp_a_valid_o(rrsp_a_valid_o), .rrsp_a_ready_i(rrsp_a_ready_i), .rrsp_a_data_o(rrsp_a_data_o),
    .rreq_b_valid_i(rreq_b_valid_i), .rreq_b_ready_o(rreq_b_ready_o), .rreq_b_addr_i(rreq_b_addr_i),
    .rrsp_b_valid_o(rrsp_b_valid_o), .rrsp_b_ready_i(rrsp_b_ready_i), .rrsp_b_data_o(rrsp_b_data_o),
    .sram_we_o(sram_we_o), .sram_waddr_o(sram_waddr_o), .sram_wdata_o(sram_wdata_o),
    .sram_addr_ra_o(sram_addr_ra_o), .sram_rdata_ra_i(sram_rdata_ra_i),
    .sram_addr_rb_o(sram_addr_rb_o), .sram_rdata_rb_i(sram_rdata_rb_i),
    .init_done_o(init_done_o), .dbg_state_o(dbg_state_o)
  );

  // SRAM model: registered reads return pre-write contents; seeded with garbage
  logic [DW-1:0] mem [256];
  logic seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hBAD0_0000 | i;
      seeded <= 1'b1;
    end else if (sram_we_o) begin
      mem[sram_waddr_o] <= sram_wdata_o;
    end
    sram_rdata_ra_i <= mem[sram_addr_ra_o];
    sram_rdata_rb_i <= mem[sram_addr_rb_o];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pop on every response handshake
  always @(negedge clk) begin
    if (rrsp_a_valid_o && rrsp_a_ready_i) begin
      if (exp_a_q.size() == 0) check("rsp_a_unexpected", 1, 0);
      else check("rsp_a_data", rrsp_a_data_o, exp_a_q.pop_front());
    end
    if (rrsp_b_valid_o && rrsp_b_ready_i) begin
      if (exp_b_q.size() == 0) check("rsp_b_unexpected", 1, 0);
      else check("rsp_b_data", rrsp_b_data_o, exp_b_q.pop_front());
    end
  end

  // clear-sequence monitor: writes must walk 0..255 with zero data
  always @(negedge clk) begin
    if (!rst_ni) begin
      init_wr_cnt = 0;
    end else if (sram_we_o && !init_done_o) begin
      check("init_wr", {sram_waddr_o, sram_wdata_o}, {init_wr_cnt[AW-1:0], 32'h0});
      init_wr_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // driver tasks: called and returning at posedge+1
  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wreq_valid_i = 1'b1;
    wreq_addr_i  = addr;
    wreq_data_i  = data;
    @(negedge clk);
    check("wr_ready", wreq_ready_o, 1);
    check("wr_sram", {sram_we_o, sram_waddr_o, sram_wdata_o}, {1'b1, addr, data});
    @(posedge clk); #1;
    wreq_valid_i = 1'b0;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    bit got = 0;
    if (port == 0) begin rreq_a_valid_i = 1'b1; rreq_a_addr_i = addr; end
    else begin rreq_b_valid_i = 1'b1; rreq_b_addr_i = addr; end
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (port == 0 && rreq_a_ready_o) begin exp_a_q.push_back(exp); got = 1; end
      if (port == 1 && rreq_b_ready_o) begin exp_b_q.push_back(exp); got = 1; end
      @(posedge clk); #1;
    end
    if (!got) check("rd_accept_timeout", 0, 1);
    if (port == 0) rreq_a_valid_i = 1'b0;
    else rreq_b_valid_i = 1'b0;
  endtask

  task automatic run_init(input string name);
    int cycles = 0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    while (!init_done_o && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({name, "_cycles"}, cycles, 256);
    check({name, "_writes"}, init_wr_cnt, 256);
    check({name, "_state"}, 64'(dbg_state_o), 64'(RUN));
    check({name, "_readys"}, {wreq_ready_o, rreq_a_ready_o, rreq_b_ready_o}, 3'b111);
  endtask

  initial begin
    int stall;
    bit got;
    rst_ni = 1'b0;
    wreq_valid_i = 1'b0; wreq_addr_i = '0; wreq_data_i = '0;
    rreq_a_valid_i = 1'b0; rreq_a_addr_i = '0; rrsp_a_ready_i = 1'b1;
    rreq_b_valid_i = 1'b0; rreq_b_addr_i = '0; rrsp_b_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {init_done_o, rrsp_a_valid_o, rrsp_b_valid_o, wreq_ready_o,
                       rreq_a_ready_o, rreq_b_ready_o, sram_we_o}, 7'b0);
    check("rst_data", {rrsp_a_data_o, rrsp_b_data_o}, 64'h0);
    check("rst_state", 64'(dbg_state_o), 64'(INIT));

    run_init("init");
    rd(0, 8'hFF, 32'h0000_0000);
    rd(1, 8'h00, 32'h0000_0000);

    wr(8'h10, 32'hDEAD_BEEF);
    rd(0, 8'h10, 32'hDEAD_BEEF);

    // write and two colliding reads in one cycle
    wreq_valid_i = 1'b1; wreq_addr_i = 8'h20; wreq_data_i = 32'h1234_5678;
    rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'h20;
    rreq_b_valid_i = 1'b1; rreq_b_addr_i = 8'h20;
    @(negedge clk);
    check("fwd_readys", {wreq_ready_o, rreq_a_ready_o, rreq_b_ready_o}, 3'b111);
    exp_a_q.push_back(32'h1234_5678);
    exp_b_q.push_back(32'h1234_5678);
    @(posedge clk); #1;
    wreq_valid_i = 1'b0; rreq_a_valid_i = 1'b0; rreq_b_valid_i = 1'b0;
    rd(0, 8'h20, 32'h1234_5678);
    rd(1, 8'h10, 32'hDEAD_BEEF);

    for (int i = 1; i <= 4; i++) wr(AW'(i), 32'hA0 + i);

    // back-to-back reads on B with a 3-cycle stall on the second response
    rreq_b_valid_i = 1'b1;
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      rreq_b_addr_i = AW'(i + 1);
      if (i == 2) rrsp_b_ready_i = 1'b0;
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (rreq_b_ready_o) begin
          exp_b_q.push_back(32'hA1 + i);
          got = 1;
        end else begin
          check("stall_hold", {rrsp_b_valid_o, rrsp_b_data_o}, {1'b1, 32'hA2});
          stall++;
        end
        @(posedge clk); #1;
        if (stall == 3) rrsp_b_ready_i = 1'b1;
      end
      if (!got) check("b_seq_timeout", 0, 1);
    end
    rreq_b_valid_i = 1'b0;
    check("stall_cycles", stall, 3);
    repeat (4) @(posedge clk);
    #1;
    check("drain_a", exp_a_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);

    // reset with a response pending on A
    rrsp_a_ready_i = 1'b0;
    rreq_a_valid_i = 1'b1; rreq_a_addr_i = 8'h10;
    @(negedge clk);
    check("pend_accept", rreq_a_ready_o, 1);
    @(posedge clk); #1;
    rreq_a_valid_i = 1'b0;
    @(negedge clk);
    check("pend_rsp", {rrsp_a_valid_o, rrsp_a_data_o}, {1'b1, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    rst_ni = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rerst_outs", {init_done_o, rrsp_a_valid_o, rrsp_b_valid_o, wreq_ready_o,
                         rreq_a_ready_o, rreq_b_ready_o}, 6'b0);
    check("rerst_data", rrsp_a_data_o, 32'h0);
    check("rerst_state", 64'(dbg_state_o), 64'(INIT));
    rrsp_a_ready_i = 1'b1;
    run_init("reinit");
    rd(0, 8'h10, 32'h0000_0000);
    rd(1, 8'h20, 32'h0000_0000);
    repeat (3) @(posedge clk);
    #1;
    check("final_drain", exp_a_q.size() + exp_b_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
